// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit core: ALU op encodings, the zero register
// and the ID/EX control bundle whose all-zero value is the pipeline bubble.
package cpu_pkg;

    localparam int unsigned ALU_OP_W = 4;
    localparam int unsigned REG_ZERO = 0;

    typedef enum logic [ALU_OP_W-1:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluAnd  = 4'd2,
        AluOr   = 4'd3,
        AluXor  = 4'd4,
        AluSll  = 4'd5,
        AluSrl  = 4'd6,
        AluSra  = 4'd7,
        AluSlt  = 4'd8,
        AluPass = 4'd9
    } alu_op_e;

    typedef struct packed {
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
        logic                alu_src;
        logic [ALU_OP_W-1:0] alu_op;
    } id_ctrl_t;

    localparam id_ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the load sitting in ID/EX and
// the instruction currently in ID.
module load_use_detect #(
    parameter int unsigned REG_AW = 4
) (
    input  logic              idex_valid_i,
    input  logic              idex_mem_read_i,
    input  logic [REG_AW-1:0] idex_rd_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_uses_rs_i,
    input  logic              id_uses_rt_i,
    input  logic              id_mem_write_i,
    output logic              hz_o
);
    import cpu_pkg::*;

    logic load_in_ex;
    logic rs_hit;
    logic rt_hit;

    always_comb begin
        load_in_ex = idex_valid_i & idex_mem_read_i & (idex_rd_i != REG_AW'(REG_ZERO));
        rs_hit     = id_uses_rs_i & (id_rs_i == idex_rd_i);
        // Store data (rt) is covered by MEM-to-MEM forwarding, so it never stalls.
        rt_hit     = id_uses_rt_i & (id_rt_i == idex_rd_i) & ~id_mem_write_i;
        hz_o       = load_in_ex & id_valid_i & (rs_hit | rt_hit);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch flush, memory freeze and
// a saturating count of inserted bubbles.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned REG_AW  = 4,
    parameter int unsigned ALUOP_W = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               Freeze,
    input  logic               Flush,
    input  logic               ID_valid,
    input  logic [REG_AW-1:0]  ID_rs,
    input  logic [REG_AW-1:0]  ID_rt,
    input  logic [REG_AW-1:0]  ID_rd,
    input  logic               ID_uses_rs,
    input  logic               ID_uses_rt,
    input  logic [DATA_W-1:0]  ID_rs_data,
    input  logic [DATA_W-1:0]  ID_rt_data,
    input  logic [DATA_W-1:0]  ID_imm,
    input  logic               ID_RegWrite,
    input  logic               ID_MemRead,
    input  logic               ID_MemWrite,
    input  logic               ID_MemtoReg,
    input  logic               ID_ALUSrc,
    input  logic [ALUOP_W-1:0] ID_ALUOp,
    output logic               IDEX_valid,
    output logic [REG_AW-1:0]  IDEX_rs,
    output logic [REG_AW-1:0]  IDEX_rt,
    output logic [REG_AW-1:0]  IDEX_rd,
    output logic [DATA_W-1:0]  IDEX_rs_data,
    output logic [DATA_W-1:0]  IDEX_rt_data,
    output logic [DATA_W-1:0]  IDEX_imm,
    output logic               IDEX_RegWrite,
    output logic               IDEX_MemRead,
    output logic               IDEX_MemWrite,
    output logic               IDEX_MemtoReg,
    output logic               IDEX_ALUSrc,
    output logic [ALUOP_W-1:0] IDEX_ALUOp,
    output logic               Stall,
    output logic [CNT_W-1:0]   StallCount
);

    logic              valid_q,   valid_d;
    logic [REG_AW-1:0] rs_q,      rs_d;
    logic [REG_AW-1:0] rt_q,      rt_d;
    logic [REG_AW-1:0] rd_q,      rd_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic [DATA_W-1:0] imm_q,     imm_d;
    id_ctrl_t          ctrl_q,    ctrl_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;

    id_ctrl_t id_ctrl;
    logic     hz;
    logic     load_bubble;

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_load_use_detect (
        .idex_valid_i    (valid_q),
        .idex_mem_read_i (ctrl_q.mem_read),
        .idex_rd_i       (rd_q),
        .id_valid_i      (ID_valid),
        .id_rs_i         (ID_rs),
        .id_rt_i         (ID_rt),
        .id_uses_rs_i    (ID_uses_rs),
        .id_uses_rt_i    (ID_uses_rt),
        .id_mem_write_i  (ID_MemWrite),
        .hz_o            (hz)
    );

    always_comb begin
        id_ctrl.reg_write  = ID_RegWrite;
        id_ctrl.mem_read   = ID_MemRead;
        id_ctrl.mem_write  = ID_MemWrite;
        id_ctrl.mem_to_reg = ID_MemtoReg;
        id_ctrl.alu_src    = ID_ALUSrc;
        id_ctrl.alu_op     = ALU_OP_W'(ID_ALUOp);
    end

    // Flush overrides the hazard so IF/ID is free to take the branch target.
    assign Stall       = hz & ~Flush;
    assign load_bubble = Flush | hz | ~ID_valid;

    always_comb begin
        valid_d   = valid_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rd_d      = rd_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        ctrl_d    = ctrl_q;
        cnt_d     = cnt_q;

        if (!Freeze) begin
            if (load_bubble) begin
                valid_d   = 1'b0;
                rs_d      = '0;
                rt_d      = '0;
                rd_d      = '0;
                rs_data_d = '0;
                rt_data_d = '0;
                imm_d     = '0;
                ctrl_d    = CTRL_NOP;
            end else begin
                valid_d   = 1'b1;
                rs_d      = ID_rs;
                rt_d      = ID_rt;
                rd_d      = ID_rd;
                rs_data_d = ID_rs_data;
                rt_data_d = ID_rt_data;
                imm_d     = ID_imm;
                ctrl_d    = id_ctrl;
            end

            if (Stall && !(&cnt_q)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            ctrl_q    <= CTRL_NOP;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            ctrl_q    <= ctrl_d;
            cnt_q     <= cnt_d;
        end
    end

    assign IDEX_valid    = valid_q;
    assign IDEX_rs       = rs_q;
    assign IDEX_rt       = rt_q;
    assign IDEX_rd       = rd_q;
    assign IDEX_rs_data  = rs_data_q;
    assign IDEX_rt_data  = rt_data_q;
    assign IDEX_imm      = imm_q;
    assign IDEX_RegWrite = ctrl_q.reg_write;
    assign IDEX_MemRead  = ctrl_q.mem_read;
    assign IDEX_MemWrite = ctrl_q.mem_write;
    assign IDEX_MemtoReg = ctrl_q.mem_to_reg;
    assign IDEX_ALUSrc   = ctrl_q.alu_src;
    assign IDEX_ALUOp    = ALUOP_W'(ctrl_q.alu_op);
    assign StallCount    = cnt_q;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline stage of the 5-stage 16-bit core. It registers decoded operands, register indices and control from ID, and supplies the IDEX_* fields that the forwarding unit and the EX stage consume. It contains load-use hazard detection, which stalls IF/ID and inserts a bubble. It also handles branch flush and global memory freeze, and keeps a saturating stall-cycle counter for performance.

Parameters:
DATA_W, 16, datapath/operand width
REG_AW, 4, register index width (16 registers; R0 hardwired zero)
ALUOP_W, 4, ALU operation code width
CNT_W, 16, stall counter width

Ports:
clk  in  1  core clock
rst_n  in  1  reset; asynchronous, active-low
Freeze  in  1  memory busy; hold all state this cycle
Flush  in  1  squash ID-stage instruction (taken branch)
ID_valid  in  1  ID holds a real instruction
ID_rs, ID_rt, ID_rd  in  REG_AW  source/source/destination indices
ID_uses_rs, ID_uses_rt  in  1  instruction actually reads rs/rt
ID_rs_data, ID_rt_data  in  DATA_W  register file read data
ID_imm  in  DATA_W  sign/zero-extended immediate
ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc  in  1  control
ID_ALUOp  in  ALUOP_W  ALU operation
IDEX_valid  out  1  EX holds a real instruction
IDEX_rs, IDEX_rt, IDEX_rd  out  REG_AW  registered indices
IDEX_rs_data, IDEX_rt_data, IDEX_imm  out  DATA_W  registered operands
IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_MemtoReg, IDEX_ALUSrc  out  1  registered control
IDEX_ALUOp  out  ALUOP_W  registered ALU op
Stall  out  1  hold PC and IF/ID (combinational)
StallCount  out  CNT_W  saturating count of bubble cycles

Behaviour:
- Reset (rst_n=0, async): every IDEX_* output = 0 (this equals a bubble); StallCount = 0.
- Bubble definition: IDEX_valid = 0, all control = 0, IDEX_rs/rt/rd = 0, data/imm = 0. Index 0 is ignored by forwarding, so a bubble can never be forwarded.
- Load-use hazard (combinational): hz = IDEX_valid & IDEX_MemRead & (IDEX_rd != 0) & ID_valid & ((ID_uses_rs & ID_rs == IDEX_rd) | (ID_uses_rt & ID_rt == IDEX_rd & !ID_MemWrite)).
- A store whose data register (rt) matches the load destination does not stall, because MEM2MEM forwarding covers it. A store whose address register (rs) matches does stall.
- Stall = hz & !Flush.
- Next-state priority, evaluated at the clk rising edge:
  1. Freeze=1: hold all registers; StallCount holds.
  2. Flush=1: load bubble.
  3. hz=1: load bubble; StallCount += 1, saturating at all-ones.
  4. Otherwise: capture ID_* fields. IDEX_valid = ID_valid. If ID_valid=0, capture a bubble instead of the raw fields.
- Latency: 1 cycle ID to IDEX. A load-use pair costs exactly 1 bubble; the dependent instruction enters ID/EX on the next non-frozen cycle, when the load has moved to EX/MEM and hz is 0.
- Freeze during a stall: Stall stays asserted (hz unchanged), no bubble is counted, and the state is held.
- Flush together with hz: flush wins, and Stall=0 so IF/ID can be redirected.
- Reset released mid-stream: the first edge after release captures ID normally.

Decomposition:
- Shared package cpu_pkg: ALUOp encodings, the REG_ZERO constant, and an id_ctrl_t struct bundling RegWrite/MemRead/MemWrite/MemtoReg/ALUSrc/ALUOp, so the bubble is a single constant, CTRL_NOP.
- One sub-module: load_use_detect, the combinational hz equation, instantiated once.

Test Plan:
- Load into R3 in EX, ID is ADD R5=R3+R4 (uses_rs, rs=3) -> Stall=1. Next edge: IDEX_valid=0, IDEX_rd=0, StallCount=1. Following cycle: Stall=0, ADD captured with IDEX_rs=3.
- Load into R3 in EX, ID is SW R3->[R6] (rt=3, MemWrite=1) -> Stall=0; SW captured next edge with IDEX_rt=3, IDEX_MemWrite=1.
- Load into R0 in EX, ID reads R0 -> Stall=0 (zero register exempt).
- Freeze=1 for 3 cycles while the IDEX contents are ADD rd=7 -> outputs unchanged each cycle, StallCount unchanged. On Freeze=0, the next ID instruction is captured.
- Flush=1 while hz=1 -> Stall=0; next edge gives a bubble, StallCount unchanged.
- Drive hz continuously with CNT_W=4 -> StallCount saturates at 15. Assert rst_n=0 between edges -> all outputs 0 immediately.
